// File: rtl/salu_issue_if.sv
// ---------------------------------------------------------------------------
// salu_issue_if
//   Decoded-instruction issue channel into the scalar ALU issue stage.
//
//   Handshake: a transfer happens on a rising clk edge where in_valid_i and
//   in_ready_o are both 1. While in_valid_i is 1 and in_ready_o is 0 the
//   producer holds the instruction fields stable; the consumer may drive
//   in_ready_o independently of in_valid_i.
//
//   Members:
//     in_valid_i     instruction valid               (master -> slave)
//     in_ready_o     stage can accept                (slave  -> master)
//     in_op_i        4-bit ALU opcode                (master -> slave)
//     in_rs1_addr_i  source 1 index                  (master -> slave)
//     in_rs2_addr_i  source 2 index                  (master -> slave)
//     in_rd_addr_i   destination index               (master -> slave)
//     in_rd_we_i     instruction writes rd           (master -> slave)
//     in_use_imm_i   operand 2 is in_imm_i           (master -> slave)
//     in_imm_i       sign-extended immediate         (master -> slave)
// ---------------------------------------------------------------------------
interface salu_issue_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [3:0]                in_op_i;
    logic [REG_ADDR_WIDTH-1:0] in_rs1_addr_i;
    logic [REG_ADDR_WIDTH-1:0] in_rs2_addr_i;
    logic [REG_ADDR_WIDTH-1:0] in_rd_addr_i;
    logic                      in_rd_we_i;
    logic                      in_use_imm_i;
    logic [DATA_WIDTH-1:0]     in_imm_i;

    modport master (
        output in_valid_i, in_op_i, in_rs1_addr_i, in_rs2_addr_i,
               in_rd_addr_i, in_rd_we_i, in_use_imm_i, in_imm_i,
        input  in_ready_o
    );

    modport slave (
        input  in_valid_i, in_op_i, in_rs1_addr_i, in_rs2_addr_i,
               in_rd_addr_i, in_rd_we_i, in_use_imm_i, in_imm_i,
        output in_ready_o
    );
endinterface

// File: rtl/salu_issue.sv
// ---------------------------------------------------------------------------
// salu_issue
//   Issue/operand stage in front of the scalar ALU. Accepts decoded
//   instructions, reads the register file, resolves RAW hazards against the
//   two instructions in flight (X = ALU input, W = ALU result), and tracks
//   the destination tag for writeback.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     flush_i             kill X/W and refuse the incoming instruction
//     in_if (slave)       decoded instruction valid/ready channel
//     rf_rs*_addr_o       regfile read addresses (combinational)
//     rf_rs*_data_i       regfile read data (combinational, not write-through)
//     alu_res_i           registered ALU result of the W instruction
//     rs1/rs2_data_o      ALU operands (X slot)
//     alu_op_o            ALU opcode (X slot)
//     x_valid_o           X slot holds a real instruction
//     wb_valid_o          alu_res_i belongs to a real instruction
//     wb_rd_addr_o        destination of the W instruction
//     wb_rd_we_o          write regfile with alu_res_i this cycle
//
//   Optional (macro SALU_ISSUE_PERF_EN):
//     perf_issue_cnt_o    accepted instructions, wraps at 2^32
//     perf_stall_cnt_o    cycles with in_valid_i & stall, wraps at 2^32
// ---------------------------------------------------------------------------
module salu_issue #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    salu_issue_if.slave               in_if,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr_o,
    input  logic [DATA_WIDTH-1:0]     rf_rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rf_rs2_data_i,
    input  logic [DATA_WIDTH-1:0]     alu_res_i,
    output logic [DATA_WIDTH-1:0]     rs1_data_o,
    output logic [DATA_WIDTH-1:0]     rs2_data_o,
    output logic [3:0]                alu_op_o,
    output logic                      x_valid_o,
    output logic                      wb_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_o,
    output logic                      wb_rd_we_o
`ifdef SALU_ISSUE_PERF_EN
    ,
    output logic [31:0]               perf_issue_cnt_o,
    output logic [31:0]               perf_stall_cnt_o
`endif
);

    // X slot
    logic                      x_valid_q, x_valid_d;
    logic                      x_we_q,    x_we_d;
    logic [REG_ADDR_WIDTH-1:0] x_rd_q,    x_rd_d;
    logic [3:0]                x_op_q,    x_op_d;
    logic [DATA_WIDTH-1:0]     x_rs1_q,   x_rs1_d;
    logic [DATA_WIDTH-1:0]     x_rs2_q,   x_rs2_d;
    // W slot (tag only; data arrives on alu_res_i)
    logic                      w_valid_q, w_valid_d;
    logic                      w_we_q,    w_we_d;
    logic [REG_ADDR_WIDTH-1:0] w_rd_q,    w_rd_d;

    logic                      rs1_zero, rs2_zero;
    logic                      fwd_rs1, fwd_rs2;
    logic                      haz_rs1, haz_rs2;
    logic                      stall, accept;
    logic [DATA_WIDTH-1:0]     op1_sel, op2_sel;

    assign rf_rs1_addr_o = in_if.in_rs1_addr_i;
    assign rf_rs2_addr_o = in_if.in_rs2_addr_i;

    always_comb begin
        rs1_zero = (in_if.in_rs1_addr_i == '0);
        rs2_zero = (in_if.in_rs2_addr_i == '0);

        // W forward: regfile only sees this value after the W cycle ends.
        fwd_rs1 = w_valid_q & w_we_q & (w_rd_q == in_if.in_rs1_addr_i);
        fwd_rs2 = w_valid_q & w_we_q & (w_rd_q == in_if.in_rs2_addr_i);

        // X producer's result does not exist yet: wait one cycle, then it
        // sits in W and is forwarded. Writes to x0 never create a hazard.
        haz_rs1 = x_valid_q & x_we_q & (x_rd_q != '0)
                & (x_rd_q == in_if.in_rs1_addr_i);
        haz_rs2 = x_valid_q & x_we_q & (x_rd_q != '0)
                & (x_rd_q == in_if.in_rs2_addr_i) & ~in_if.in_use_imm_i;
        stall   = haz_rs1 | haz_rs2;

        in_if.in_ready_o = ~stall & ~flush_i;
        accept           = in_if.in_valid_i & in_if.in_ready_o;

        if (rs1_zero)     op1_sel = '0;
        else if (fwd_rs1) op1_sel = alu_res_i;
        else              op1_sel = rf_rs1_data_i;

        if (in_if.in_use_imm_i) op2_sel = in_if.in_imm_i;
        else if (rs2_zero)      op2_sel = '0;
        else if (fwd_rs2)       op2_sel = alu_res_i;
        else                    op2_sel = rf_rs2_data_i;

        // Default X load is a bubble (ADD 0,0, no write).
        x_valid_d = 1'b0;
        x_we_d    = 1'b0;
        x_rd_d    = '0;
        x_op_d    = 4'd0;
        x_rs1_d   = '0;
        x_rs2_d   = '0;
        if (accept) begin
            x_valid_d = 1'b1;
            x_we_d    = in_if.in_rd_we_i;
            x_rd_d    = in_if.in_rd_addr_i;
            x_op_d    = in_if.in_op_i;
            x_rs1_d   = op1_sel;
            x_rs2_d   = op2_sel;
        end

        // W follows X every cycle; the ALU never back-pressures.
        w_valid_d = x_valid_q & ~flush_i;
        w_we_d    = x_we_q & ~flush_i;
        w_rd_d    = x_rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_valid_q <= 1'b0;
            x_we_q    <= 1'b0;
            x_rd_q    <= '0;
            x_op_q    <= 4'd0;
            x_rs1_q   <= '0;
            x_rs2_q   <= '0;
            w_valid_q <= 1'b0;
            w_we_q    <= 1'b0;
            w_rd_q    <= '0;
        end else begin
            x_valid_q <= x_valid_d;
            x_we_q    <= x_we_d;
            x_rd_q    <= x_rd_d;
            x_op_q    <= x_op_d;
            x_rs1_q   <= x_rs1_d;
            x_rs2_q   <= x_rs2_d;
            w_valid_q <= w_valid_d;
            w_we_q    <= w_we_d;
            w_rd_q    <= w_rd_d;
        end
    end

    assign rs1_data_o   = x_rs1_q;
    assign rs2_data_o   = x_rs2_q;
    assign alu_op_o     = x_op_q;
    assign x_valid_o    = x_valid_q;
    assign wb_valid_o   = w_valid_q;
    assign wb_rd_addr_o = w_rd_q;
    assign wb_rd_we_o   = w_we_q;

`ifdef SALU_ISSUE_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        // accept already excludes flush cycles
        if (accept)                                 perf_issue_d = perf_issue_q + 32'd1;
        if (in_if.in_valid_i & stall & ~flush_i)    perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt_o = perf_issue_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_salu_issue.sv
// ---------------------------------------------------------------------------
// tb_salu_issue
//   Directed bench for salu_issue. The bench plays both the register file
//   (rf_rs*_data_i) and the ALU (alu_res_i); expected values are written
//   by hand next to each step.
// ---------------------------------------------------------------------------
module tb_salu_issue;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush_i = 1'b0;
    logic [DW-1:0] rf_rs1_data_i = '0;
    logic [DW-1:0] rf_rs2_data_i = '0;
    logic [DW-1:0] alu_res_i = '0;
    logic [AW-1:0] rf_rs1_addr_o, rf_rs2_addr_o, wb_rd_addr_o;
    logic [DW-1:0] rs1_data_o, rs2_data_o;
    logic [3:0]    alu_op_o;
    logic          x_valid_o, wb_valid_o, wb_rd_we_o;
`ifdef SALU_ISSUE_PERF_EN
    logic [31:0]   perf_issue_cnt_o, perf_stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    salu_issue_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) in_if ();

    salu_issue #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_if         (in_if),
        .rf_rs1_addr_o (rf_rs1_addr_o),
        .rf_rs2_addr_o (rf_rs2_addr_o),
        .rf_rs1_data_i (rf_rs1_data_i),
        .rf_rs2_data_i (rf_rs2_data_i),
        .alu_res_i     (alu_res_i),
        .rs1_data_o    (rs1_data_o),
        .rs2_data_o    (rs2_data_o),
        .alu_op_o      (alu_op_o),
        .x_valid_o     (x_valid_o),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_addr_o  (wb_rd_addr_o),
        .wb_rd_we_o    (wb_rd_we_o)
`ifdef SALU_ISSUE_PERF_EN
        ,
        .perf_issue_cnt_o (perf_issue_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [3:0] op,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we,
                         input logic use_imm, input logic [DW-1:0] imm);
        in_if.in_valid_i    = valid;
        in_if.in_op_i       = op;
        in_if.in_rs1_addr_i = rs1;
        in_if.in_rs2_addr_i = rs2;
        in_if.in_rd_addr_i  = rd;
        in_if.in_rd_we_i    = we;
        in_if.in_use_imm_i  = use_imm;
        in_if.in_imm_i      = imm;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        idle();
        // ---------------- reset ----------------
        #1 rst = 1'b1;
        #1;
        check("rst_x_valid",  32'(x_valid_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_we",    32'(wb_rd_we_o), 32'd0);
        check("rst_rs1",      rs1_data_o, 32'd0);
        check("rst_rs2",      rs2_data_o, 32'd0);
        check("rst_op",       32'(alu_op_o), 32'd0);
        check("rst_wb_rd",    32'(wb_rd_addr_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_ready",   32'(in_if.in_ready_o), 32'd1);
        check("idle_x_valid", 32'(x_valid_o), 32'd0);
        check("idle_wb_valid",32'(wb_valid_o), 32'd0);

        // ---------------- ADD x3,x1,x2 ; x1=5 x2=7 ----------------
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0);
        rf_rs1_data_i = 32'd5;
        rf_rs2_data_i = 32'd7;
        #1;
        check("rf_addr1", 32'(rf_rs1_addr_o), 32'd1);
        check("rf_addr2", 32'(rf_rs2_addr_o), 32'd2);
        tick();
        check("add_x_valid", 32'(x_valid_o), 32'd1);
        check("add_rs1",     rs1_data_o, 32'd5);
        check("add_rs2",     rs2_data_o, 32'd7);
        check("add_op",      32'(alu_op_o), 32'd0);
        idle();
        tick();
        check("add_wb_valid", 32'(wb_valid_o), 32'd1);
        check("add_wb_rd",    32'(wb_rd_addr_o), 32'd3);
        check("add_wb_we",    32'(wb_rd_we_o), 32'd1);
        check("add_x_bubble", 32'(x_valid_o), 32'd0);
        tick();

        // ---------------- ADD x3,x1,x2 ; SUB x4,x3,x1 ----------------
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0);
        rf_rs1_data_i = 32'd5;
        rf_rs2_data_i = 32'd7;
        tick();
        drive(1'b1, 4'd1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 32'd0);
        rf_rs1_data_i = 32'hDEAD;   // stale x3 in regfile
        rf_rs2_data_i = 32'd5;
        #1;
        check("raw_stall_ready", 32'(in_if.in_ready_o), 32'd0);
        tick();
        check("raw_bubble_valid", 32'(x_valid_o), 32'd0);
        check("raw_bubble_rs1",   rs1_data_o, 32'd0);
        check("raw_bubble_op",    32'(alu_op_o), 32'd0);
        check("raw_prod_in_w",    32'(wb_rd_addr_o), 32'd3);
        alu_res_i = 32'd12;
        #1;
        check("raw_ready_again", 32'(in_if.in_ready_o), 32'd1);
        tick();
        check("sub_x_valid", 32'(x_valid_o), 32'd1);
        check("sub_rs1_fwd", rs1_data_o, 32'd12);
        check("sub_rs2",     rs2_data_o, 32'd5);
        check("sub_op",      32'(alu_op_o), 32'd1);
        check("sub_w_bubble",32'(wb_valid_o), 32'd0);
        idle();
        alu_res_i = 32'd0;
        tick();
        tick();

        // ---------------- x0 producer then x0 consumer ----------------
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 32'd0);
        rf_rs1_data_i = 32'd5;
        rf_rs2_data_i = 32'd7;
        tick();
        drive(1'b1, 4'd0, 5'd0, 5'd1, 5'd6, 1'b1, 1'b0, 32'd0);
        rf_rs1_data_i = 32'h55;     // must be ignored for x0
        rf_rs2_data_i = 32'd5;
        #1;
        check("x0_no_stall", 32'(in_if.in_ready_o), 32'd1);
        tick();
        check("x0_x_valid",  32'(x_valid_o), 32'd1);
        check("x0_rs1_zero", rs1_data_o, 32'd0);
        check("x0_rs2",      rs2_data_o, 32'd5);
        check("x0_wb_rd",    32'(wb_rd_addr_o), 32'd0);
        check("x0_wb_we",    32'(wb_rd_we_o), 32'd1);
        idle();
        tick();
        tick();

        // ---------------- ADDI reading x5 while W writes x5 ----------------
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'd0);
        rf_rs1_data_i = 32'd5;
        rf_rs2_data_i = 32'd7;
        tick();
        idle();
        tick();
        alu_res_i = 32'h10;
        drive(1'b1, 4'd0, 5'd5, 5'd5, 5'd8, 1'b1, 1'b1, 32'hFFFF_FFFF);
        rf_rs1_data_i = 32'h77;
        rf_rs2_data_i = 32'h66;
        #1;
        check("addi_ready", 32'(in_if.in_ready_o), 32'd1);
        tick();
        check("addi_rs1_fwd", rs1_data_o, 32'h10);
        check("addi_rs2_imm", rs2_data_o, 32'hFFFF_FFFF);
        check("addi_x_valid", 32'(x_valid_o), 32'd1);
        // X now writes x8: rs2 match ignored with immediate, stalls without
        alu_res_i = 32'd0;
        drive(1'b1, 4'd0, 5'd0, 5'd8, 5'd9, 1'b1, 1'b1, 32'd1);
        #1;
        check("imm_rs2_no_haz", 32'(in_if.in_ready_o), 32'd1);
        in_if.in_use_imm_i = 1'b0;
        #1;
        check("rs2_haz_stall", 32'(in_if.in_ready_o), 32'd0);
        idle();
        tick();
        tick();

        // ---------------- flush during a stall ----------------
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b1, 4'd0, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 32'd0);
        flush_i = 1'b1;
        #1;
        check("flush_ready", 32'(in_if.in_ready_o), 32'd0);
        tick();
        check("flush_x_valid",  32'(x_valid_o), 32'd0);
        check("flush_wb_valid", 32'(wb_valid_o), 32'd0);
        check("flush_wb_we",    32'(wb_rd_we_o), 32'd0);
        flush_i = 1'b0;
        idle();
        tick();

        // ---------------- reset mid-stream ----------------
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 32'd0);
        tick();
        check("pre_rst_wb_valid", 32'(wb_valid_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_x_valid",  32'(x_valid_o), 32'd0);
        check("mid_rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("mid_rst_rs1",      rs1_data_o, 32'd0);
        idle();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_if.in_ready_o), 32'd1);
`ifdef SALU_ISSUE_PERF_EN
        check("perf_issue_rst", perf_issue_cnt_o, 32'd0);
        check("perf_stall_rst", perf_stall_cnt_o, 32'd0);
`endif
        tick();

        // ---------------- 3 issues, 1 stall ----------------
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0);
        rf_rs1_data_i = 32'd5;
        rf_rs2_data_i = 32'd7;
        tick();
        drive(1'b1, 4'd1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 32'd0);
        rf_rs2_data_i = 32'd5;
        tick();
        alu_res_i = 32'd12;
        tick();
        check("perf_seq_sub_rs1", rs1_data_o, 32'd12);
        alu_res_i = 32'd0;
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 32'd0);
        rf_rs1_data_i = 32'd5;
        rf_rs2_data_i = 32'd7;
        tick();
        check("b2b_x_valid", 32'(x_valid_o), 32'd1);
        check("b2b_wb_rd",   32'(wb_rd_addr_o), 32'd4);
        idle();
        tick();
        check("b2b_wb_rd2",  32'(wb_rd_addr_o), 32'd12);
`ifdef SALU_ISSUE_PERF_EN
        check("perf_issue_cnt", perf_issue_cnt_o, 32'd3);
        check("perf_stall_cnt", perf_stall_cnt_o, 32'd1);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/salu_issue.md
Name: salu_issue

Overview:
- Issue/operand stage directly upstream of the scalar ALU.
- Accepts decoded ALU instructions over a valid/ready handshake and reads the register file.
- Resolves RAW hazards against the two instructions in flight: forwards from the ALU result, or stalls one cycle.
- Registers rs1/rs2/op into the ALU input and tracks the destination tag alongside the ALU's own 1-cycle pipeline for writeback.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_ADDR_WIDTH, 5, register index width (x0 hardwired zero)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
flush_i  in  1  kill all in-flight and incoming state
in_valid_i  in  1  decoded instruction valid
in_ready_o  out  1  stage can accept
in_op_i  in  4  ALU opcode (same 4-bit encoding the ALU decodes)
in_rs1_addr_i  in  REG_ADDR_WIDTH  source 1 index
in_rs2_addr_i  in  REG_ADDR_WIDTH  source 2 index
in_rd_addr_i  in  REG_ADDR_WIDTH  destination index
in_rd_we_i  in  1  instruction writes rd
in_use_imm_i  in  1  operand 2 = in_imm_i instead of rs2
in_imm_i  in  DATA_WIDTH  sign-extended immediate
rf_rs1_addr_o  out  REG_ADDR_WIDTH  regfile read port 1 address (= in_rs1_addr_i, combinational)
rf_rs2_addr_o  out  REG_ADDR_WIDTH  regfile read port 2 address
rf_rs1_data_i  in  DATA_WIDTH  combinational read data 1
rf_rs2_data_i  in  DATA_WIDTH  combinational read data 2
alu_res_i  in  DATA_WIDTH  registered ALU result (instruction in W stage)
rs1_data_o  out  DATA_WIDTH  ALU operand 1
rs2_data_o  out  DATA_WIDTH  ALU operand 2
alu_op_o  out  4  ALU opcode
x_valid_o  out  1  operands in X (ALU input) are a real instruction
wb_valid_o  out  1  alu_res_i belongs to a real instruction
wb_rd_addr_o  out  REG_ADDR_WIDTH  destination of W instruction
wb_rd_we_o  out  1  write regfile with alu_res_i this cycle

Behaviour:
- Two tracked slots: X (registered outputs feeding the ALU) and W (tag delayed one more cycle, aligned with alu_res_i).
- Every cycle, W <= X (valid, rd, we) unconditionally; ALU never back-pressures.
- Operand select for incoming instruction, per source, priority order:
  - addr == 0 -> 0.
  - W valid & W we & W rd == addr -> alu_res_i.
  - Otherwise rf data.
  - Operand 2 is in_imm_i when in_use_imm_i=1, and no rs2 hazard check is applied.
- Hazard: X valid & X we & X rd != 0 & X rd matches a used source -> stall.
  - in_ready_o=0; X loads a bubble (x_valid_o=0, rd_we=0, op=ADD, operands 0).
  - Next cycle the producer is in W and is forwarded.
- in_ready_o = !stall & !flush_i (combinational).
- Accept = in_valid_i & in_ready_o -> X loads the selected operands, op, rd, we; x_valid_o=1.
- No accept and no stall -> X loads a bubble.
- Latency: accepted instruction on ALU inputs next cycle; result on alu_res_i / wb_valid_o one cycle after that.
- Regfile is written at the end of the W cycle; the regfile is not write-through, hence the W forward.
- rd = 0 with we=1: wb_rd_we_o still asserted (regfile ignores x0); never forwarded, never stalls.
- flush_i=1: X and W valid/we clear on the next edge; the incoming instruction is not accepted. A flush in the same cycle as a stall is still honoured.
- Reset (async, rst=1):
  - x_valid_o=0, wb_valid_o=0, wb_rd_we_o=0.
  - rs1_data_o=0, rs2_data_o=0, alu_op_o=0 (ADD), wb_rd_addr_o=0.
  - in_ready_o=1 after release.
- Back-to-back independent instructions issue every cycle (full throughput).

Optional Feature:
- Macro SALU_ISSUE_PERF_EN.
- Defined: adds outputs perf_issue_cnt_o[31:0] (accepted instructions) and perf_stall_cnt_o[31:0] (cycles with in_valid_i & stall).
  - Both counters reset to 0 and wrap modulo 2^32.
  - Neither counter increments during flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then idle -> all outputs 0, in_ready_o=1, x_valid_o=0, wb_valid_o=0.
- ADD x3,x1,x2 with rf x1=5, x2=7 -> next cycle rs1=5, rs2=7, op=0, x_valid=1; following cycle wb_rd_addr=3, wb_rd_we=1.
- ADD x3,x1,x2 then SUB x4,x3,x1 back-to-back:
  - in_ready_o=0 for one cycle, X bubble.
  - SUB issues with rs1_data_o=alu_res_i=12, rs2=5 (no regfile value used).
- Producer to x0, then consumer of x0 -> no stall, operand 0.
- ADDI (use_imm=1, imm=-1) reading x5 while the W instruction writes x5=0x10 -> rs1=0x10, rs2=0xFFFFFFFF.
- flush_i during a stall cycle, and rst asserted mid-stream -> X/W valid clear; with SALU_ISSUE_PERF_EN, counters match accepted/stalled counts (e.g. 3 and 1).
